powerup_controller: RTL

Owns the single falling power-up object: answers the `generate_powerup` pulse and start column issued by the game-start/power-up scheduler, advances the object down the screen once per frame, detects pickup by the player or a miss at the bottom edge, and drives `powerup_exists` back to the scheduler so that no second object is requested while one is live. Sits between the scheduler, the player-position logic and the sprite renderer, all clocked by `frame_clk`.

---
 rtl/game_pkg.sv | 34 +++
 rtl/powerup_effect_timer.sv | 46 ++++
 rtl/powerup_controller.sv | 126 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: power-up FSM encoding, screen limits, coordinate
// types and the interval-overlap helper used for pickup detection.
package game_pkg;

    localparam int unsigned COORD_W      = 10;
    localparam int unsigned SCREEN_Y_MAX = 479;
    localparam int unsigned SCREEN_X_MAX = 639;

    typedef logic [COORD_W-1:0] coord_t;
    // One extra bit so that position + size never wraps.
    typedef logic [COORD_W:0]   coord_ext_t;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        FALLING = 1'b1
    } powerup_state_t;

    // Zero-extend a screen coordinate into the wide comparison domain.
    function automatic coord_ext_t coord_ext(input coord_t v);
        return {1'b0, v};
    endfunction

    // Half-open interval overlap [a_lo, a_lo+a_len) vs [b_lo, b_lo+b_len).
    // An empty interval (length 0) never overlaps anything.
    function automatic logic span_overlap(input coord_ext_t a_lo,
                                          input coord_ext_t a_len,
                                          input coord_ext_t b_lo,
                                          input coord_ext_t b_len);
        logic non_empty;
        non_empty = (a_len != coord_ext_t'(0)) && (b_len != coord_ext_t'(0));
        return non_empty && (a_lo < (b_lo + b_len)) && (b_lo < (a_lo + a_len));
    endfunction

endpackage

// File: rtl/powerup_effect_timer.sv
// Pickup effect timer: loads EFFECT_FRAMES on a pickup, counts down once per
// frame, and flags the effect as active while the count is non-zero.
module powerup_effect_timer
    import game_pkg::*;
#(
    parameter int unsigned EFFECT_FRAMES = 600
) (
    input  logic frame_clk,
    input  logic Reset,
    input  logic load,
    output logic active
);

    localparam int unsigned CNT_W = $clog2(EFFECT_FRAMES + 1);
    typedef logic [CNT_W-1:0] cnt_t;

    cnt_t count_r;
    cnt_t count_next_s;
    logic active_r;

    // Next count: a pickup reloads (also while already active), else count down to zero.
    always_comb begin
        count_next_s = count_r;
        if (load) begin
            count_next_s = cnt_t'(EFFECT_FRAMES);
        end else if (count_r != cnt_t'(0)) begin
            count_next_s = count_r - cnt_t'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register and registered active flag derived from the next count.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            count_r  <= cnt_t'(0);
            active_r <= 1'b0;
        end else begin
            count_r  <= count_next_s;
            active_r <= (count_next_s != cnt_t'(0));
        end
    end

    assign active = active_r;

endmodule

// File: rtl/powerup_controller.sv
// Falling power-up object controller: spawns on a scheduler request, falls
// FALL_SPEED pixels per frame, and ends on player pickup or bottom exit.
// Optional pickup effect timer enabled with `define POWERUP_EFFECT_TIMER_EN.
module powerup_controller
    import game_pkg::*;
#(
    parameter int unsigned FALL_SPEED    = 2,
    parameter int unsigned PU_SIZE       = 16,
    parameter int unsigned START_Y       = 0,
    parameter int unsigned Y_MAX         = SCREEN_Y_MAX,
    parameter int unsigned EFFECT_FRAMES = 600
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic               generate_powerup,
    input  logic [COORD_W-1:0] powerup_startpos,
    input  logic [COORD_W-1:0] player_x,
    input  logic [COORD_W-1:0] player_y,
    input  logic [COORD_W-1:0] player_w,
    input  logic [COORD_W-1:0] player_h,
    output logic               powerup_exists,
    output logic [COORD_W-1:0] powerup_x,
    output logic [COORD_W-1:0] powerup_y,
    output logic               powerup_collected,
    output logic               powerup_missed,
    output logic               powerup_active
);

    localparam coord_ext_t PU_SIZE_EXT    = coord_ext_t'(PU_SIZE);
    localparam coord_ext_t FALL_SPEED_EXT = coord_ext_t'(FALL_SPEED);
    localparam coord_ext_t Y_MAX_EXT      = coord_ext_t'(Y_MAX);
    localparam coord_t     START_Y_C      = coord_t'(START_Y);

    powerup_state_t state_r;
    powerup_state_t state_next_s;
    coord_t         x_r;
    coord_t         y_r;
    coord_t         x_next_s;
    coord_t         y_next_s;
    logic           collected_r;
    logic           missed_r;
    logic           collected_next_s;
    logic           missed_next_s;
    logic           hit_s;
    coord_ext_t     y_step_s;

    // Overlap is evaluated on the registered object position, never on next values.
    assign hit_s = span_overlap(coord_ext(x_r), PU_SIZE_EXT,
                                coord_ext(player_x), coord_ext(player_w)) &&
                   span_overlap(coord_ext(y_r), PU_SIZE_EXT,
                                coord_ext(player_y), coord_ext(player_h));

    assign y_step_s = coord_ext(y_r) + FALL_SPEED_EXT;

    // Next-state logic: spawn from IDLE; in FALLING, pickup beats miss beats falling.
    always_comb begin
        state_next_s     = state_r;
        x_next_s         = x_r;
        y_next_s         = y_r;
        collected_next_s = 1'b0;
        missed_next_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (generate_powerup) begin
                    state_next_s = FALLING;
                    x_next_s     = powerup_startpos;
                    y_next_s     = START_Y_C;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FALLING: begin
                // Requests arriving here are dropped, including on the exit frame.
                if (hit_s) begin
                    state_next_s     = IDLE;
                    collected_next_s = 1'b1;
                end else if (y_step_s > Y_MAX_EXT) begin
                    state_next_s  = IDLE;
                    missed_next_s = 1'b1;
                end else begin
                    y_next_s = y_step_s[COORD_W-1:0];
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, position and pulse registers; reset discards any live object silently.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_r     <= IDLE;
            x_r         <= coord_t'(0);
            y_r         <= coord_t'(0);
            collected_r <= 1'b0;
            missed_r    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            x_r         <= x_next_s;
            y_r         <= y_next_s;
            collected_r <= collected_next_s;
            missed_r    <= missed_next_s;
        end
    end

    assign powerup_exists    = (state_r == FALLING);
    assign powerup_x         = x_r;
    assign powerup_y         = y_r;
    assign powerup_collected = collected_r;
    assign powerup_missed    = missed_r;

`ifdef POWERUP_EFFECT_TIMER_EN
    powerup_effect_timer #(
        .EFFECT_FRAMES (EFFECT_FRAMES)
    ) u_effect_timer (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .load      (collected_next_s),
        .active    (powerup_active)
    );
`else
    assign powerup_active = 1'b0;
`endif

endmodule
